// File: rtl/cw310_usb_reg_fe_pkg.sv
// Shared definitions for the CW310 USB register-bus front end.
package cw310_usb_reg_fe_pkg;

  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CAPT  = 3'd1,
    RD_HOLD  = 3'd2,
    WR_PULSE = 3'd3,
    WR_WAIT  = 3'd4
  } fe_state_e;

endpackage

// File: rtl/cw310_strobe_sync.sv
// Two-flop synchroniser for an asynchronous bus strobe, plus a history flop
// for edge detection. Resets to 1 (strobe inactive).
module cw310_strobe_sync
  import cw310_usb_reg_fe_pkg::*;
#(
  parameter bit pFALLING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic edge_out
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_DEPTH-1:0] sync_ff;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '1;
      hist    <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[SYNC_DEPTH-2:0], async_in};
      hist    <= sync_ff[SYNC_DEPTH-1];
    end
  end

  assign sync_out = sync_ff[SYNC_DEPTH-1];
  assign edge_out = pFALLING ? (hist & ~sync_out) : (~hist & sync_out);

endmodule

// File: rtl/cw310_usb_reg_fe.sv
// SAM3U external-memory bus to register-block front end.
// Optional burst byte counter enabled by defining USB_BURST_EN.
module cw310_usb_reg_fe
  import cw310_usb_reg_fe_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                               usb_clk,
  input  logic                               reset_i,
  input  logic [pADDR_WIDTH-1:0]             usb_addr,
  input  logic [7:0]                         usb_din,
  output logic [7:0]                         usb_dout,
  output logic                               usb_isout,
  input  logic                               usb_cen,
  input  logic                               usb_rdn,
  input  logic                               usb_wrn,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
  output logic [7:0]                         write_data,
  input  logic [7:0]                         read_data,
  output logic                               reg_read,
  output logic                               reg_write,
  output logic                               reg_addrvalid
);

  fe_state_e state, state_nxt;

  logic cen_s, rdn_s, wrn_s;
  logic rdn_fell, wrn_rose;
  logic rd_go, wr_go;
  logic [pBYTECNT_SIZE-1:0] access_bcnt;

  logic [7:0]                             dout_nxt, wdata_nxt;
  logic                                   isout_nxt, read_nxt, write_nxt, av_nxt;
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   addr_nxt;
  logic [pBYTECNT_SIZE-1:0]               bcnt_nxt;

`ifdef USB_BURST_EN
  logic cen_fell;
`else
  logic unused_cen_fell;
`endif

  cw310_strobe_sync #(.pFALLING(1'b1)) u_sync_cen (
    .clk      (usb_clk),
    .rst      (reset_i),
    .async_in (usb_cen),
    .sync_out (cen_s),
`ifdef USB_BURST_EN
    .edge_out (cen_fell)
`else
    .edge_out (unused_cen_fell)
`endif
  );

  cw310_strobe_sync #(.pFALLING(1'b1)) u_sync_rdn (
    .clk      (usb_clk),
    .rst      (reset_i),
    .async_in (usb_rdn),
    .sync_out (rdn_s),
    .edge_out (rdn_fell)
  );

  cw310_strobe_sync #(.pFALLING(1'b0)) u_sync_wrn (
    .clk      (usb_clk),
    .rst      (reset_i),
    .async_in (usb_wrn),
    .sync_out (wrn_s),
    .edge_out (wrn_rose)
  );

  // A write edge wins over a read edge seen in the same cycle.
  assign wr_go = (state == IDLE) && !cen_s && wrn_rose;
  assign rd_go = (state == IDLE) && !cen_s && rdn_fell && !wrn_rose;

`ifdef USB_BURST_EN
  logic [pBYTECNT_SIZE-1:0] burst_cnt;

  // A cen falling edge coincident with an access must use the reloaded value.
  assign access_bcnt = cen_fell ? usb_addr[pBYTECNT_SIZE-1:0] : burst_cnt;

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i)
      burst_cnt <= '0;
    else if (wr_go || rd_go)
      burst_cnt <= access_bcnt + pBYTECNT_SIZE'(1);
    else if (cen_fell)
      burst_cnt <= usb_addr[pBYTECNT_SIZE-1:0];
  end
`else
  assign access_bcnt = usb_addr[pBYTECNT_SIZE-1:0];
`endif

  always_comb begin
    state_nxt = state;
    dout_nxt  = usb_dout;
    isout_nxt = usb_isout;
    addr_nxt  = reg_address;
    bcnt_nxt  = reg_bytecnt;
    wdata_nxt = write_data;
    read_nxt  = reg_read;
    write_nxt = reg_write;
    av_nxt    = reg_addrvalid;
    case (state)
      IDLE: begin
        if (wr_go) begin
          addr_nxt  = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
          bcnt_nxt  = access_bcnt;
          wdata_nxt = usb_din;
          write_nxt = 1'b1;
          av_nxt    = 1'b1;
          state_nxt = WR_PULSE;
        end else if (rd_go) begin
          addr_nxt  = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
          bcnt_nxt  = access_bcnt;
          read_nxt  = 1'b1;
          av_nxt    = 1'b1;
          state_nxt = RD_CAPT;
        end
      end
      RD_CAPT: begin
        dout_nxt  = read_data;
        isout_nxt = wrn_s;
        read_nxt  = 1'b0;
        av_nxt    = 1'b0;
        state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        // Also release the pins if a write strobe shows up, so we never fight the host.
        if (rdn_s || cen_s || !wrn_s) begin
          isout_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      WR_PULSE: begin
        write_nxt = 1'b0;
        av_nxt    = 1'b0;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: state_nxt = IDLE;
      default: begin
        isout_nxt = 1'b0;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        av_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      usb_dout      <= '0;
      usb_isout     <= 1'b0;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      write_data    <= '0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      reg_addrvalid <= 1'b0;
    end else begin
      state         <= state_nxt;
      usb_dout      <= dout_nxt;
      usb_isout     <= isout_nxt;
      reg_address   <= addr_nxt;
      reg_bytecnt   <= bcnt_nxt;
      write_data    <= wdata_nxt;
      reg_read      <= read_nxt;
      reg_write     <= write_nxt;
      reg_addrvalid <= av_nxt;
    end
  end

endmodule
